// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// FSM state encoding and the step-counter width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to hold a step count from 0 up to n_steps inclusive.
    function automatic int cnt_width(input int n_steps);
        return $clog2(n_steps + 1);
    endfunction

endpackage

// File: rtl/seq_mag_cmp_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
// Equality is implied when neither gt nor lt is set.
module digit_cmp #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             gt,
    output logic             lt
);

    assign gt = (da > db);
    assign lt = (da < db);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator. Operands are captured on an accepted
// start and compared DIGIT bits per cycle, MSB first, stopping at the first
// differing digit. Signed mode flips the sign bits on capture so that the
// remaining walk is a plain unsigned compare (offset-binary trick).
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_N    = CW'(N);

    if (((WIDTH % DIGIT) != 0) || (WIDTH < 2)) begin : g_param_check
        $error("seq_mag_cmp: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] sa_q,      sa_d;
    logic [WIDTH-1:0] sb_q,      sb_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             equal_q,   equal_d;
    logic             greater_q, greater_d;
    logic             less_q,    less_d;

    logic dig_gt;
    logic dig_lt;

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .da (sa_q[WIDTH-1 -: DIGIT]),
        .db (sb_q[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    // Next-state, datapath and registered-output computation for the FSM.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        equal_d   = equal_q;
        greater_d = greater_q;
        less_d    = less_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d      = signed_mode ? (a ^ MSB_MASK) : a;
                    sb_d      = signed_mode ? (b ^ MSB_MASK) : b;
                    cnt_d     = CNT_N;
                    equal_d   = 1'b0;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dig_gt || dig_lt) begin
                    // First differing digit decides the result.
                    greater_d = dig_gt;
                    less_d    = dig_lt;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Last digit matched as well: operands are equal.
                        equal_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                equal_d   = 1'b0;
                greater_d = 1'b0;
                less_d    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sa_q      <= {WIDTH{1'b0}};
            sb_q      <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
            less_q    <= less_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign equal   = equal_q;
    assign greater = greater_q;
    assign less    = less_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed scoreboard bench for seq_mag_cmp: one instance with DIGIT=1 and
// one with DIGIT=2, sharing operands and reset.
module tb_seq_mag_cmp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sel = 1'b0;

    logic busy1, done1, eq1, gt1, lt1;
    logic busy2, done2, eq2, gt2, lt2;
    logic busy_m, done_m, eq_m, gt_m, lt_m;

    typedef struct {
        string tag;
        logic  eq;
        logic  gt;
        logic  lt;
        int    k;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_mag_cmp #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy1), .done(done1),
        .equal(eq1), .greater(gt1), .less(lt1)
    );

    seq_mag_cmp #(.WIDTH(8), .DIGIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy2), .done(done2),
        .equal(eq2), .greater(gt2), .less(lt2)
    );

    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;
    assign eq_m   = sel ? eq2   : eq1;
    assign gt_m   = sel ? gt2   : gt1;
    assign lt_m   = sel ? lt2   : lt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result from integer compare, k from first differing digit.
    function automatic exp_t model(input string tag, input logic [7:0] av,
                                   input logic [7:0] bv, input logic m,
                                   input int digit);
        exp_t e;
        logic signed [7:0] as_s;
        logic signed [7:0] bs_s;
        int xi;
        bit found;
        as_s = av;
        bs_s = bv;
        e.tag = tag;
        e.eq  = (av == bv);
        if (m) begin
            e.gt = (as_s > bs_s);
            e.lt = (as_s < bs_s);
        end else begin
            e.gt = (av > bv);
            e.lt = (av < bv);
        end
        xi = int'(av ^ bv);
        e.k = 8 / digit;
        found = 1'b0;
        for (int d = 1; d <= 8 / digit; d++) begin
            if (!found && (((xi >> (8 - digit * d)) & ((1 << digit) - 1)) != 0)) begin
                e.k = d;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    // Drive a start (optionally aligned to a falling edge), pass E0, check busy.
    task automatic launch(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic m, input logic s, input bit wait_neg);
        if (wait_neg) @(negedge clk);
        a = av;
        b = bv;
        signed_mode = m;
        sel = s;
        if (s) start2 = 1'b1;
        else   start1 = 1'b1;
        sb_q.push_back(model(tag, av, bv, m, s ? 2 : 1));
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        chk({tag, "_busy_e0"}, busy_m, 1);
        chk({tag, "_done_e0"}, done_m, 0);
    endtask

    // Wait (bounded) for done, then compare latency and result with the scoreboard.
    task automatic finish_op();
        int cyc;
        exp_t e;
        cyc = 0;
        e = sb_q[0];
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start2 = 1'b0;
            cyc++;
            if (done_m) break;
            chk({e.tag, "_busy_run"}, busy_m, 1);
        end
        e = sb_q.pop_front();
        last_e = e;
        chk({e.tag, "_done"},    done_m, 1);
        chk({e.tag, "_latency"}, cyc,    e.k);
        chk({e.tag, "_busy_dn"}, busy_m, 0);
        chk({e.tag, "_equal"},   eq_m,   e.eq);
        chk({e.tag, "_greater"}, gt_m,   e.gt);
        chk({e.tag, "_less"},    lt_m,   e.lt);
    endtask

    // One cycle after done: pulse must be gone, results must hold.
    task automatic post_check();
        @(posedge clk);
        #1;
        chk({last_e.tag, "_done_pulse"}, done_m, 0);
        chk({last_e.tag, "_busy_idle"},  busy_m, 0);
        chk({last_e.tag, "_hold_eq"},    eq_m,   last_e.eq);
        chk({last_e.tag, "_hold_gt"},    gt_m,   last_e.gt);
        chk({last_e.tag, "_hold_lt"},    lt_m,   last_e.lt);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy",    busy1, 0);
        chk("rst_done",    done1, 0);
        chk("rst_equal",   eq1,   0);
        chk("rst_greater", gt1,   0);
        chk("rst_less",    lt1,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 0x80 > 0x7F decided on the first digit
        launch("u80_7f", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1);
        finish_op();
        post_check();

        // Signed: -128 < 127
        launch("s80_7f", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);
        finish_op();
        post_check();

        // Equal operands walk all 8 digits
        launch("eq5a", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);
        finish_op();
        post_check();

        // LSB decides, DIGIT=1 then DIGIT=2
        launch("d1_03_02", 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
        finish_op();
        post_check();
        launch("d2_03_02", 8'h03, 8'h02, 1'b0, 1'b1, 1'b1);
        finish_op();
        post_check();

        // Signed mixed-sign on the DIGIT=2 instance: -1 < 1
        launch("d2_sff_01", 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);
        finish_op();
        post_check();

        // Start during RUN is ignored; third start in DONE is accepted
        launch("prot_10_20", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        a = 8'hFF;
        b = 8'h00;
        start1 = 1'b1;
        finish_op();
        launch("b2b_c3_c4", 8'hC3, 8'hC4, 1'b0, 1'b0, 1'b0);
        finish_op();
        post_check();

        // Asynchronous reset in the middle of a compare
        launch("abort", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",    busy1, 0);
        chk("arst_done",    done1, 0);
        chk("arst_equal",   eq1,   0);
        chk("arst_greater", gt1,   0);
        chk("arst_less",    lt1,   0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // First op after reset: signed -2 < -1
        launch("s_fe_ff", 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1);
        finish_op();
        post_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
